// File: rtl/stage1_fetch.sv
// rtl/stage1_fetch.sv - RV32I stage-1 fetch: PC register, icache drive, stage-1/2 pipeline register
module stage1_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_Next,
    input  logic        PC_Sel,
    input  logic        stall,
    input  logic [31:0] icache_dout,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    output logic [31:0] PC_4,
    output logic [31:0] PC_X,
    output logic [31:0] Inst_X,
    output logic        Valid_X
);

    localparam logic PC_SEL_PC_4 = 1'b0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc_f;
    logic [31:0] hold_reg;
    logic        hold_valid;
    logic [31:0] inst_f;

    // The memory read for pc_f lands on icache_dout one cycle later; during a
    // stall the memory is not re-read, so the captured word stands in for it.
    assign inst_f = hold_valid ? hold_reg : icache_dout;

    assign PC_4 = pc_f + 32'd4;

    // State register: BOOT lasts exactly one cycle after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next state and instruction memory request.
    always_comb begin
        next_state  = state;
        icache_re   = 1'b0;
        icache_addr = RESET_PC;
        if (!reset) begin
            case (state)
                BOOT: begin
                    icache_re   = 1'b1;
                    icache_addr = RESET_PC;
                    next_state  = RUN;
                end
                RUN: begin
                    if (stall) begin
                        icache_re   = 1'b0;
                        icache_addr = pc_f;
                    end else begin
                        icache_re   = 1'b1;
                        icache_addr = PC_Next;
                    end
                end
                default: begin
                    next_state = BOOT;
                end
            endcase
        end
    end

    // Fetch PC: advances to the mux output on every unstalled RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (state == RUN && !stall) begin
            pc_f <= PC_Next;
        end
    end

    // Hold buffer: capture the in-flight read on the first stalled edge only,
    // since later stalled cycles present no valid read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg   <= NOP_INST;
            hold_valid <= 1'b0;
        end else if (state == RUN) begin
            if (stall) begin
                if (!hold_valid) begin
                    hold_reg   <= icache_dout;
                    hold_valid <= 1'b1;
                end
            end else begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Stage-1/2 register: a redirect turns the wrong-path fetch into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_X    <= 32'd0;
            Inst_X  <= NOP_INST;
            Valid_X <= 1'b0;
        end else if (state == BOOT) begin
            PC_X    <= 32'd0;
            Inst_X  <= NOP_INST;
            Valid_X <= 1'b0;
        end else if (!stall) begin
            PC_X <= pc_f;
            if (PC_Sel == PC_SEL_PC_4) begin
                Inst_X  <= inst_f;
                Valid_X <= 1'b1;
            end else begin
                Inst_X  <= NOP_INST;
                Valid_X <= 1'b0;
            end
        end
    end

endmodule
